// File: rtl/merge_select_ctrl.sv
// merge_select_ctrl: select/stall controller for one 2-input node of a merge tree.
// Optional stall statistics are built when MERGE_CTRL_STATS_EN is defined.
`default_nettype none

module merge_select_ctrl #(
  parameter int KEY_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [KEY_W-1:0] i_a_key,
  input  logic [KEY_W-1:0] i_b_key,
  input  logic             i_a_empty,
  input  logic             i_b_empty,
  input  logic             i_out_full,
  output logic             o_select_a,
  output logic             o_stall,
  output logic             o_discard,
  output logic             o_switch_output,
  output logic             o_run_done,
  output logic [CNT_W-1:0] o_run_count,
  output logic [CNT_W-1:0] o_stall_cycles
);

  typedef enum logic [2:0] {
    ST_MERGE   = 3'd0,
    ST_DRAIN_A = 3'd1,
    ST_DRAIN_B = 3'd2,
    ST_TERM_A  = 3'd3,
    ST_TERM_B  = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             prev_sel;
  logic [CNT_W-1:0] run_count;

  logic a_zero;
  logic b_zero;
  logic need_a;
  logic need_b;
  logic sel_a;
  logic discard_st;
  logic done_st;
  logic stall_raw;
  logic accepted;

  assign a_zero = (i_a_key == '0);
  assign b_zero = (i_b_key == '0);

  always_comb begin
    need_a     = 1'b0;
    need_b     = 1'b0;
    sel_a      = 1'b1;
    discard_st = 1'b0;
    done_st    = 1'b0;
    state_nxt  = state;
    case (state)
      ST_MERGE: begin
        need_a = 1'b1;
        need_b = 1'b1;
        if (a_zero && b_zero) begin
          // Both runs ended: emit A's terminator, drop B's later.
          sel_a     = 1'b1;
          done_st   = 1'b1;
          state_nxt = ST_TERM_B;
        end else if (b_zero) begin
          sel_a     = 1'b1;
          state_nxt = ST_DRAIN_A;
        end else if (a_zero) begin
          sel_a     = 1'b0;
          state_nxt = ST_DRAIN_B;
        end else begin
          sel_a = (i_a_key <= i_b_key);
        end
      end
      ST_DRAIN_A: begin
        need_a = 1'b1;
        sel_a  = 1'b1;
        if (a_zero) begin
          done_st   = 1'b1;
          state_nxt = ST_TERM_B;
        end
      end
      ST_DRAIN_B: begin
        need_b = 1'b1;
        sel_a  = 1'b0;
        if (b_zero) begin
          done_st   = 1'b1;
          state_nxt = ST_TERM_A;
        end
      end
      ST_TERM_A: begin
        need_a     = 1'b1;
        sel_a      = 1'b1;
        discard_st = 1'b1;
        state_nxt  = ST_MERGE;
      end
      ST_TERM_B: begin
        need_b     = 1'b1;
        sel_a      = 1'b0;
        discard_st = 1'b1;
        state_nxt  = ST_MERGE;
      end
      default: state_nxt = ST_MERGE;
    endcase
  end

  assign stall_raw = i_out_full | (need_a & i_a_empty) | (need_b & i_b_empty);
  assign accepted  = ~i_rst & ~stall_raw;

  assign o_stall         = i_rst | stall_raw;
  assign o_select_a      = i_rst | sel_a;
  assign o_discard       = accepted & discard_st;
  assign o_switch_output = accepted & (sel_a != prev_sel);
  assign o_run_done      = accepted & done_st;
  assign o_run_count     = i_rst ? '0 : run_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_MERGE;
      prev_sel  <= 1'b1;
      run_count <= '0;
    end else if (accepted) begin
      state <= state_nxt;
      if (!discard_st) begin
        prev_sel <= sel_a;
      end
      if (done_st) begin
        run_count <= run_count + 1'b1;
      end
    end
  end

`ifdef MERGE_CTRL_STATS_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_cnt <= '0;
    end else if (stall_raw && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign o_stall_cycles = i_rst ? '0 : stall_cnt;
`else
  assign o_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_merge_select_ctrl.sv
// tb_merge_select_ctrl: directed bench for merge_select_ctrl with FIFO head queues.
`default_nettype none

module tb_merge_select_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_key;
  logic [31:0] b_key;
  logic        a_empty;
  logic        b_empty;
  logic        out_full;
  logic        select_a;
  logic        stall;
  logic        discard;
  logic        switch_output;
  logic        run_done;
  logic [15:0] run_count;
  logic [15:0] stall_cycles;

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          checks    = 0;
  int          failures  = 0;
  int          runs_exp  = 0;
  int          stall_exp = 0;

  always #5 clk = ~clk;

  merge_select_ctrl #(.KEY_W(32), .CNT_W(16)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_a_key         (a_key),
    .i_b_key         (b_key),
    .i_a_empty       (a_empty),
    .i_b_empty       (b_empty),
    .i_out_full      (out_full),
    .o_select_a      (select_a),
    .o_stall         (stall),
    .o_discard       (discard),
    .o_switch_output (switch_output),
    .o_run_done      (run_done),
    .o_run_count     (run_count),
    .o_stall_cycles  (stall_cycles)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive_heads();
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
    a_key   = a_empty ? 32'hDEAD_BEEF : qa[0];
    b_key   = b_empty ? 32'hDEAD_BEEF : qb[0];
  endtask

  function automatic logic [31:0] stall_model();
`ifdef MERGE_CTRL_STATS_EN
    return stall_exp;
`else
    return 32'd0;
`endif
  endfunction

  // One clock: present heads, check decode, then pop the queue the model says was dequeued.
  task automatic step(input string tag, input bit e_stall, input bit e_sel,
                      input bit e_disc, input bit e_sw, input bit e_done);
    drive_heads();
    #2;
    check({tag, ".stall"}, {31'd0, stall}, {31'd0, e_stall});
    if (!e_stall) check({tag, ".sel"}, {31'd0, select_a}, {31'd0, e_sel});
    check({tag, ".disc"}, {31'd0, discard}, {31'd0, e_disc});
    check({tag, ".sw"}, {31'd0, switch_output}, {31'd0, e_sw});
    check({tag, ".done"}, {31'd0, run_done}, {31'd0, e_done});
    @(posedge clk);
    if (!e_stall) begin
      if (e_sel) void'(qa.pop_front());
      else       void'(qb.pop_front());
    end
    if (e_stall) stall_exp++;
    if (e_done)  runs_exp++;
    #1;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".runs"}, {16'd0, run_count}, runs_exp);
    check({tag, ".stallcnt"}, {16'd0, stall_cycles}, stall_model());
  endtask

  initial begin
    rst = 1'b1; out_full = 1'b0;
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    check("rst.stall", {31'd0, stall}, 32'd1);
    check("rst.sel", {31'd0, select_a}, 32'd1);
    check("rst.done", {31'd0, run_done}, 32'd0);
    rst = 1'b0;
    #1;
    check_counters("rst");

    // Interleaved merge; A's terminator shows first, so B drains then A's zero is dropped.
    qa = {32'd3, 32'd7, 32'd0};
    qb = {32'd5, 32'd9, 32'd0};
    step("t1a", 0, 1, 0, 0, 0);
    step("t1b", 0, 0, 0, 1, 0);
    step("t1c", 0, 1, 0, 1, 0);
    step("t1d", 0, 0, 0, 1, 0);
    step("t1e", 0, 0, 0, 0, 1);
    step("t1f", 0, 1, 1, 1, 0);
    check_counters("t1");

    // Equal keys: tie goes to A.
    qa = {32'd4, 32'd0};
    qb = {32'd4, 32'd0};
    step("t2a", 0, 1, 0, 1, 0);
    step("t2b", 0, 0, 0, 1, 0);
    step("t2c", 0, 0, 0, 0, 1);
    step("t2d", 0, 1, 1, 1, 0);
    check_counters("t2");

    // Empty run on A.
    qa = {32'd0};
    qb = {32'd2, 32'd6, 32'd0};
    step("t3a", 0, 0, 0, 0, 0);
    step("t3b", 0, 0, 0, 0, 0);
    step("t3c", 0, 0, 0, 0, 1);
    step("t3d", 0, 1, 1, 1, 0);
    check_counters("t3");

    // Downstream backpressure mid-run.
    qa = {32'd1, 32'd0};
    qb = {32'd2, 32'd0};
    step("t4a", 0, 1, 0, 1, 0);
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) step("t4full", 1, 1, 0, 0, 0);
    check_counters("t4frz");
    out_full = 1'b0;
    step("t4b", 0, 0, 0, 1, 0);
    step("t4c", 0, 0, 0, 0, 1);
    step("t4d", 0, 1, 1, 1, 0);
    check_counters("t4");

    // B empty in MERGE stalls until data arrives.
    qa = {32'd1, 32'd0};
    for (int i = 0; i < 3; i++) step("t5wait", 1, 1, 0, 0, 0);
    qb = {32'd8, 32'd0};
    step("t5a", 0, 1, 0, 1, 0);
    step("t5b", 0, 0, 0, 1, 0);
    step("t5c", 0, 0, 0, 0, 1);
    step("t5d", 0, 1, 1, 1, 0);
    check_counters("t5");

    // Reset while draining B.
    qa = {32'd0};
    qb = {32'd5, 32'd6};
    step("t6a", 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive_heads();
    #2;
    check("t6rst.stall", {31'd0, stall}, 32'd1);
    check("t6rst.sel", {31'd0, select_a}, 32'd1);
    check("t6rst.disc", {31'd0, discard}, 32'd0);
    check("t6rst.sw", {31'd0, switch_output}, 32'd0);
    check("t6rst.done", {31'd0, run_done}, 32'd0);
    check("t6rst.runs", {16'd0, run_count}, 32'd0);
    check("t6rst.stallcnt", {16'd0, stall_cycles}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    runs_exp  = 0;
    stall_exp = 0;
    #1;
    check_counters("t6post");
    // Back in MERGE with prev_sel=1: A wins without a switch.
    qa = {32'd3, 32'd0};
    qb = {32'd4, 32'd0};
    step("t6b", 0, 1, 0, 0, 0);
    step("t6c", 0, 0, 0, 1, 0);
    step("t6d", 0, 0, 0, 0, 1);
    step("t6e", 0, 1, 1, 1, 0);
    check_counters("t6");

    // Unsigned compare with MSB set, and the DRAIN_A / TERM_B path.
    qa = {32'h8000_0000, 32'd0};
    qb = {32'd7, 32'd0};
    step("t7a", 0, 0, 0, 0, 0);
    step("t7b", 0, 1, 0, 1, 0);
    step("t7c", 0, 1, 0, 0, 1);
    step("t7d", 0, 0, 1, 1, 0);
    check_counters("t7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
